// File: rtl/fifo_uart_tx_if.sv
// Read-port and serial-line bundle between the FIFO read side and the UART transmitter.
// The master modport is the transmitter. The slave modport is the FIFO/config environment.
interface fifo_uart_tx_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
);
  logic                  fifo_empty;
  logic [WIDTH-1:0]      rdata;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  rd_en;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_done;

  modport master (
    input  fifo_empty, rdata, prescale, par_en, par_typ,
    output rd_en, tx_out, busy, frame_done
  );

  modport slave (
    output fifo_empty, rdata, prescale, par_en, par_typ,
    input  rd_en, tx_out, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx_reader.sv
// Drains one byte per frame from the FIFO's registered read port and sends it as a UART frame.
// The frame is: start bit, data bits LSB first, an optional parity bit, then one stop bit.
module fifo_uart_tx_reader #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic          R_CLK,
  input  logic          R_RST,
  fifo_uart_tx_if.master bus
);
  localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, pcnt_q, pcnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [WIDTH-1:0]      sh_q, sh_d;
  logic                  pe_q, par_q;
  logic                  rd_en_q, tx_q, busy_q, done_q;
  logic                  rd_en_d, tx_d, busy_d, done_d;
  logic                  bit_end, last_bit;

  function automatic logic [PRESCALE_W-1:0] clamp_prescale(input logic [PRESCALE_W-1:0] p);
    return (p == '0) ? PRESCALE_W'(1) : p;
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  assign bit_end  = (pcnt_q == (p_q - PRESCALE_W'(1)));
  assign last_bit = (bcnt_q == BCNT_W'(WIDTH - 1));

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      p_q     <= PRESCALE_W'(1);
      pe_q    <= 1'b0;
      par_q   <= 1'b0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      // Frame settings are frozen together with the data so mid-frame changes wait for the next byte
      if (state_q == S_WAIT) begin
        p_q   <= clamp_prescale(bus.prescale);
        pe_q  <= bus.par_en;
        par_q <= parity_of(bus.rdata, bus.par_typ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE:  if (!bus.fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_START;
        sh_d    = bus.rdata;
        pcnt_d  = '0;
        bcnt_d  = '0;
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        pcnt_d = bit_end ? '0 : pcnt_q + PRESCALE_W'(1);
        if (bit_end) begin
          case (state_q)
            S_START:  state_d = S_DATA;
            S_DATA: begin
              if (last_bit) begin
                state_d = pe_q ? S_PARITY : S_STOP;
              end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
                sh_d   = sh_q >> 1;
              end
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.tx_out     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule
